ft245_sync_tx_streamer: RTL
===========================

# ft245_sync_tx_streamer

Parametrised FPGA→FT2232H transmit engine for FT245 synchronous FIFO mode, replacing the fixed-counter demo streamer. Accepts multi-channel sample frames on a valid/ready port, serialises each frame into bytes through an internal byte FIFO, and drives the FT2232H write handshake at one byte per `clk_i` cycle while TXE# permits. Sits between the acquisition front-end and the FT2232H pins and runs in the 60 MHz CLKOUT domain.

## Interface
- `CH_N`, 4: channels per frame.
- `WORD_W`, 16: bits per channel sample; must be a multiple of 8.
- `FIFO_DEPTH`, 512: byte FIFO depth; power of 2, at least the bytes in one frame.
- `BLINK_LOG2`, 20: `blinker_o` toggles every 2^BLINK_LOG2 transferred bytes.

- `clk_i` in 1: FT2232H CLKOUT; single clock. Reset is asynchronous and active-high.
- `rst_i` in 1: asynchronous reset, active-high.
- `sample_i` in CH_N*WORD_W: frame; channel k occupies bits [k*WORD_W +: WORD_W].
- `sample_valid_i` in 1: frame valid.
- `sample_ready_o` out 1: frame accepted on an edge where valid and ready are both high.
- `adbus_o` out 8: FT data bus.
- `txe_i` in 1: FT TXE#, active-low; 0 means the FT can take data.
- `wr_o` out 1: FT WR#, active-low.
- `oe_o` out 1: FT OE#, held 1 (TX only).
- `overflow_o` out 1: sticky; set when a frame is offered while not ready.
- `drop_cnt_o` out 16: saturating count of edges with valid high and ready low.
- `blinker_o` out 1: activity indicator.

## Operation
- Reset values: `sample_ready_o`=0 during reset, 1 on the first cycle after reset. `adbus_o`=0, `wr_o`=1, `oe_o`=1, `overflow_o`=0, `drop_cnt_o`=0, `blinker_o`=0. Byte FIFO and sequence counter cleared.
- Frame bytes FB = CH_N*WORD_W/8. Byte order: channel 0 first, each word LSB byte first.
- Serialiser FSM:
  - IDLE: ready=1. On accept, latch `sample_i` and go to DATA, or to HDR0 when the header is enabled.
  - HDR0: push 0xA5.
  - HDR1: push the sequence byte, then increment it (wraps 255→0).
  - DATA: push one byte per cycle; return to IDLE after byte FB-1.
  - A push occurs only when the FIFO is not full. On a full FIFO the FSM holds its state and byte.
- Output stage: register `adbus_o`, with `out_valid` = !`wr_o`.
  - A byte transfers on an edge with `wr_o`=0 and `txe_i`=0.
  - On an edge with `out_valid`=0 or a transfer, load the FIFO head if the FIFO is non-empty; otherwise set `wr_o`=1.
  - With `txe_i`=1, `adbus_o` and `wr_o` hold. No byte is lost or duplicated.
- Simultaneous FIFO push and pop is legal, including when the FIFO is full: the pop frees a slot, but the push still sees "full" that cycle.
- `blinker_o`: a BLINK_LOG2-bit counter increments per transfer; the output toggles on wrap.
- `drop_cnt_o` saturates at 0xFFFF. `overflow_o` clears only on reset.
- Reset mid-frame: immediate abort, `wr_o`=1 asynchronously, partial frame discarded.

## Timing
- Accept at edge N → first byte pushed at edge N+1 → `wr_o`=0 with that byte on `adbus_o` after edge N+2.
- Sustained throughput: 1 byte/cycle while `txe_i`=0. Back-to-back frames leave one IDLE cycle between frames.
- `txe_i` has no synchroniser; it is synchronous to `clk_i`.

## Configuration
- `FT_TX_HEADER_EN` defined: each frame is prefixed with 0xA5 and an 8-bit sequence number, giving FB+2 bytes/frame. FIFO_DEPTH must be at least FB+2.
- Undefined: no HDR states, no sequence counter, FB bytes/frame.

## Structure
- Package `ft245_pkg`: sync byte constant 0xA5, FSM state enum, FB/frame-length function.
- Sub-module `ft_tx_byte_fifo`: synchronous show-ahead FIFO, 8-bit wide, FIFO_DEPTH deep, with full/empty flags.

## Test plan
- CH_N=2, WORD_W=16, header off, `txe_i`=0, frame {16'h1234,16'hABCD} → `adbus_o` CD,AB,34,12 on four consecutive `wr_o`=0 edges. First `wr_o`=0 is 2 cycles after accept.
- Same frame with `FT_TX_HEADER_EN` → A5,00,CD,AB,34,12. Second frame carries sequence 01. After 256 frames the sequence wraps to 00.
- `txe_i` toggles 1/0 every 3 cycles during 100 frames → byte stream identical to the `txe_i`=0 run, with no gaps, repeats or losses.
- `txe_i`=1 held, frames offered continuously → FIFO fills and `sample_ready_o`=0. `overflow_o`=1 and `drop_cnt_o` counts stalled edges, saturating at 0xFFFF.
- `rst_i` pulsed mid-frame → `wr_o`=1 immediately, all outputs at reset values, next frame starts at its first byte (sequence 00).
- BLINK_LOG2=4, 48 transfers → `blinker_o` toggles 3 times.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared constants and types for the FT245 synchronous-FIFO transmit streamer.
// Build macro FT_TX_HEADER_EN adds the header states to the FSM encoding.
package ft245_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef FT_TX_HEADER_EN
    S_HDR0,
    S_HDR1,
`endif
    S_DATA
  } tx_state_e;

  // Payload bytes carried by one frame (header bytes excluded).
  function automatic int unsigned frame_bytes(input int unsigned ch_n, input int unsigned word_w);
    return (ch_n * word_w) / 8;
  endfunction

endpackage

// File: rtl/ft245_sync_tx_streamer_if.sv
// Sample stream, FT245 bus and status signals of the transmit streamer.
// master: the streamer itself; slave: front-end / FT2232H side.
interface ft245_sync_tx_streamer_if #(
  parameter int unsigned CH_N   = 4,
  parameter int unsigned WORD_W = 16
);
  logic [CH_N*WORD_W-1:0] sample_i;
  logic                   sample_valid_i;
  logic                   sample_ready_o;
  logic [7:0]             adbus_o;
  logic                   txe_i;
  logic                   wr_o;
  logic                   oe_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;
  logic                   blinker_o;

  modport master (
    input  sample_i, sample_valid_i, txe_i,
    output sample_ready_o, adbus_o, wr_o, oe_o, overflow_o, drop_cnt_o, blinker_o
  );

  modport slave (
    output sample_i, sample_valid_i, txe_i,
    input  sample_ready_o, adbus_o, wr_o, oe_o, overflow_o, drop_cnt_o, blinker_o
  );
endinterface

// File: rtl/ft_tx_byte_fifo.sv
// Synchronous show-ahead byte FIFO: head always presents the oldest entry.
// Pointers carry one extra wrap bit to tell full from empty.
module ft_tx_byte_fifo #(
  parameter int unsigned DEPTH = 512
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer update; push is judged against the pre-pop full flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ft245_sync_tx_streamer.sv
// FT2232H FT245 synchronous-FIFO transmit engine: latches multi-channel frames,
// serialises them (channel 0 first, LSB byte first) into a byte FIFO and drives
// WR# at up to one byte per CLKOUT cycle while TXE# is low.
// Build macro FT_TX_HEADER_EN: prefix each frame with 0xA5 and a sequence byte.
module ft245_sync_tx_streamer
  import ft245_pkg::*;
#(
  parameter int unsigned CH_N       = 4,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned BLINK_LOG2 = 20
) (
  input logic clk_i,
  input logic rst_i,
  ft245_sync_tx_streamer_if.master bus
);
  localparam int unsigned FB      = frame_bytes(CH_N, WORD_W);
  localparam int unsigned FRAME_W = CH_N * WORD_W;
  localparam int unsigned IDX_W   = $clog2(FB) + 1;

  tx_state_e            state;
  logic [FRAME_W-1:0]   frame_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 ready_q;
`ifdef FT_TX_HEADER_EN
  logic [7:0]           seq_q;
`endif

  logic                 push;
  logic [7:0]           push_data;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [7:0]           head;

  logic [7:0]           adbus_q;
  logic                 wr_q;
  logic                 xfer;
  logic                 accept;

  logic                 overflow_q;
  logic [15:0]          drop_q;
  logic [BLINK_LOG2-1:0] blink_cnt_q;
  logic                 blink_q;

  assign accept = bus.sample_valid_i && ready_q;
  assign push   = (state != S_IDLE) && !full;
  assign xfer   = !wr_q && !bus.txe_i;
  // Refill the output register when it is empty or its byte leaves this edge.
  assign pop    = (wr_q || xfer) && !empty;

  // Byte offered to the FIFO in the current state; data bytes come off the
  // bottom of the shifting frame register.
  always_comb begin
    push_data = frame_q[7:0];
`ifdef FT_TX_HEADER_EN
    if (state == S_HDR0)      push_data = SYNC_BYTE;
    else if (state == S_HDR1) push_data = seq_q;
`endif
  end

  // Serialiser FSM; every non-idle state stalls while the FIFO is full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
`ifdef FT_TX_HEADER_EN
      seq_q   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            frame_q <= bus.sample_i;
            idx_q   <= '0;
            ready_q <= 1'b0;
`ifdef FT_TX_HEADER_EN
            state   <= S_HDR0;
`else
            state   <= S_DATA;
`endif
          end
        end
`ifdef FT_TX_HEADER_EN
        S_HDR0: if (!full) state <= S_HDR1;
        S_HDR1: if (!full) begin
          seq_q <= seq_q + 1'b1;
          state <= S_DATA;
        end
`endif
        S_DATA: if (!full) begin
          frame_q <= frame_q >> 8;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(FB - 1)) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ft_tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Output register: holds byte and WR# while TXE# is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adbus_q <= '0;
      wr_q    <= 1'b1;
    end else if (wr_q || xfer) begin
      if (!empty) begin
        adbus_q <= head;
        wr_q    <= 1'b0;
      end else begin
        wr_q    <= 1'b1;
      end
    end
  end

  // Overflow flag and saturating drop counter for frames offered while busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (bus.sample_valid_i && !ready_q) begin
      overflow_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  // Activity blinker: toggles each time the transfer counter wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (xfer) begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (&blink_cnt_q) blink_q <= ~blink_q;
    end
  end

  assign bus.sample_ready_o = ready_q;
  assign bus.adbus_o        = adbus_q;
  assign bus.wr_o           = wr_q;
  assign bus.oe_o           = 1'b1;
  assign bus.overflow_o     = overflow_q;
  assign bus.drop_cnt_o     = drop_q;
  assign bus.blinker_o      = blink_q;
endmodule
